// File: rtl/bcd_disp_pkg.sv
// Shared constants and types for the two-digit multiplexed 7-segment driver.
// Segment codes are active-low {g,f,e,d,c,b,a}; anodes are active-low.
package bcd_disp_pkg;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  localparam logic [1:0] AN_UNITS = 2'b10;
  localparam logic [1:0] AN_TENS  = 2'b01;
  localparam logic [1:0] AN_OFF   = 2'b11;

  typedef enum logic {
    SelUnits = 1'b0,
    SelTens  = 1'b1
  } sel_e;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes give a dash.
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Two-digit common-anode display scanner with per-frame snapshot of the digit
// pair, leading-zero blanking of tens, and enable-controlled blanking.
module bcd_scan_display
  import bcd_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          LZB         = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] tens_i,
  input  logic [3:0] units_i,
  input  logic       en_i,
  output logic [6:0] seg_o,
  output logic [1:0] an_o
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick;
  sel_e            sel_q, sel_d;
  logic [3:0]      snap_t_q, snap_t_d;
  logic [3:0]      snap_u_q, snap_u_d;
  logic [3:0]      digit;
  logic [6:0]      dec_seg;
  logic [6:0]      seg_q, seg_d;
  logic [1:0]      an_q, an_d;

  // Scan timing and frame-boundary snapshot.
  always_comb begin
    tick     = (cnt_q == CntMax);
    cnt_d    = tick ? '0 : cnt_q + CntW'(1);
    sel_d    = sel_q;
    snap_t_d = snap_t_q;
    snap_u_d = snap_u_q;
    if (tick) begin
      sel_d = (sel_q == SelUnits) ? SelTens : SelUnits;
      // TENS->UNITS is the frame boundary; both digits latch together so the
      // pair is never torn.
      if (sel_q == SelTens) begin
        snap_t_d = tens_i;
        snap_u_d = units_i;
      end
    end
  end

  assign digit = (sel_q == SelTens) ? snap_t_q : snap_u_q;

  bcd_to_7seg u_dec (
    .digit_i (digit),
    .seg_o   (dec_seg)
  );

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if (en_i) begin
      if (sel_q == SelUnits) begin
        an_d  = AN_UNITS;
        seg_d = dec_seg;
      end else if (!(LZB && (snap_t_q == 4'd0))) begin
        an_d  = AN_TENS;
        seg_d = dec_seg;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      sel_q    <= SelUnits;
      snap_t_q <= 4'd0;
      snap_u_q <= 4'd0;
      an_q     <= AN_OFF;
      seg_q    <= SEG_OFF;
    end else begin
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      snap_t_q <= snap_t_d;
      snap_u_q <= snap_u_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Bench for bcd_scan_display: LZB=1 and LZB=0 instances on shared inputs,
// checked each cycle against a frame-arithmetic model plus fixed vectors.
module tb_bcd_scan_display;

  localparam int unsigned R = 4;

  logic       clk;
  logic       rst;
  logic [3:0] tens;
  logic [3:0] units;
  logic       en;
  logic [6:0] seg1, seg0;
  logic [1:0] an1, an0;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_scan_display #(.REFRESH_DIV(R), .LZB(1'b1)) u_dut1 (
    .clk_i   (clk),
    .rst_i   (rst),
    .tens_i  (tens),
    .units_i (units),
    .en_i    (en),
    .seg_o   (seg1),
    .an_o    (an1)
  );

  bcd_scan_display #(.REFRESH_DIV(R), .LZB(1'b0)) u_dut0 (
    .clk_i   (clk),
    .rst_i   (rst),
    .tens_i  (tens),
    .units_i (units),
    .en_i    (en),
    .seg_o   (seg0),
    .an_o    (an0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: edges since reset release and the captured digit pair.
  int         n_edge;
  logic [3:0] m_t, m_u;
  logic [6:0] seg_tab [16];

  typedef struct {
    logic [3:0] t;
    logic [3:0] u;
    logic [6:0] u_seg;
    logic [1:0] t_an1;
    logic [6:0] t_seg1;
    logic [1:0] t_an0;
    logic [6:0] t_seg0;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, n_edge);
    end
  endtask

  function automatic void model_out(input int edge_no, input logic en_v, input bit lzb,
                                    output logic [1:0] an_x, output logic [6:0] seg_x);
    int slot;
    slot  = ((edge_no - 1) / R) % 2;
    an_x  = 2'b11;
    seg_x = 7'h7F;
    if (en_v) begin
      if (slot == 0) begin
        an_x  = 2'b10;
        seg_x = seg_tab[m_u];
      end else if (!(lzb && m_t == 4'd0)) begin
        an_x  = 2'b01;
        seg_x = seg_tab[m_t];
      end
    end
  endfunction

  // One clock edge with model prediction and comparison of both instances.
  task automatic step();
    logic [1:0] ea1, ea0;
    logic [6:0] es1, es0;
    model_out(n_edge + 1, en, 1'b1, ea1, es1);
    model_out(n_edge + 1, en, 1'b0, ea0, es0);
    if ((n_edge + 1) % (2 * R) == 0) begin
      m_t = tens;
      m_u = units;
    end
    @(posedge clk);
    #1;
    n_edge++;
    check("an_lzb1", int'(an1), int'(ea1));
    check("seg_lzb1", int'(seg1), int'(es1));
    check("an_lzb0", int'(an0), int'(ea0));
    check("seg_lzb0", int'(seg0), int'(es0));
  endtask

  // Asynchronous reset: outputs must blank before any further clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_an", int'(an1), 2'b11);
    check("rst_seg", int'(seg1), 7'h7F);
    check("rst_an0", int'(an0), 2'b11);
    @(posedge clk);
    #1;
    check("rst_hold_seg", int'(seg1), 7'h7F);
    rst    = 1'b0;
    n_edge = 0;
    m_t    = 4'd0;
    m_u    = 4'd0;
  endtask

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    vecs[0] = '{4'd4,  4'd7,  7'h78, 2'b01, 7'h19, 2'b01, 7'h19};
    vecs[1] = '{4'd0,  4'd5,  7'h12, 2'b11, 7'h7F, 2'b01, 7'h40};
    vecs[2] = '{4'd15, 4'd12, 7'h3F, 2'b01, 7'h3F, 2'b01, 7'h3F};
    vecs[3] = '{4'd9,  4'd0,  7'h40, 2'b01, 7'h10, 2'b01, 7'h10};
    vecs[4] = '{4'd1,  4'd8,  7'h00, 2'b01, 7'h79, 2'b01, 7'h79};

    rst    = 1'b1;
    en     = 1'b1;
    tens   = 4'd4;
    units  = 4'd7;
    n_edge = 0;
    m_t    = 4'd0;
    m_u    = 4'd0;
    #12;
    do_reset();

    // First frame after reset: units slot shows 0, tens slot blanked.
    step();
    check("first_units_an", int'(an1), 2'b10);
    check("first_units_seg", int'(seg1), 7'h40);
    repeat (R) step();
    check("first_tens_blank_an", int'(an1), 2'b11);

    // Table vectors: hold a pair for two frames, then check the third.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      tens  = vecs[i].t;
      units = vecs[i].u;
      repeat (2 * R) step();
      step();
      check("vec_units_an", int'(an1), 2'b10);
      check("vec_units_seg", int'(seg1), int'(vecs[i].u_seg));
      repeat (R - 1) step();
      step();
      check("vec_tens_an1", int'(an1), int'(vecs[i].t_an1));
      check("vec_tens_seg1", int'(seg1), int'(vecs[i].t_seg1));
      check("vec_tens_an0", int'(an0), int'(vecs[i].t_an0));
      check("vec_tens_seg0", int'(seg0), int'(vecs[i].t_seg0));
    end

    // Enable dropped for 10 cycles mid-frame; phase must continue unaffected.
    tens  = 4'd3;
    units = 4'd6;
    repeat (2 * R + 2) step();
    en = 1'b0;
    step();
    check("en_off_an", int'(an1), 2'b11);
    check("en_off_seg", int'(seg1), 7'h7F);
    repeat (9) step();
    en = 1'b1;
    repeat (3 * R) step();

    // Inputs changing every cycle, with occasional enable drops.
    for (int i = 0; i < 600; i++) begin
      tens  = 4'($urandom_range(0, 15));
      units = 4'($urandom_range(0, 15));
      en    = ($urandom_range(0, 15) != 0);
      step();
    end
    en = 1'b1;

    // Reset pulsed mid tens-slot, then restart at units showing 0.
    tens  = 4'd8;
    units = 4'd2;
    while (((n_edge / R) % 2) == 0 || (n_edge % R) == 0) step();
    do_reset();
    step();
    check("post_rst_an", int'(an1), 2'b10);
    check("post_rst_seg", int'(seg1), 7'h40);
    repeat (3 * R) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Two-digit multiplexed 7-segment display driver that consumes the BCD `tens`/`units` outputs of the counter stage. It drives a common-anode two-digit display from the counter's two digits. It time-multiplexes the digits with a programmable refresh prescaler and snapshots the input pair once per scan frame, so a digit pair is never shown half-updated. It adds leading-zero blanking, blanks the display when disabled, and shows a dash for any non-BCD code.

## Interface
- `REFRESH_DIV`, default 50000: clk cycles each digit stays lit; legal range ≥ 2.
- `LZB`, default 1: 1 enables leading-zero blanking of the tens digit.
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `tens`  in  4  BCD tens digit from the counter stage.
- `units`  in  4  BCD units digit from the counter stage.
- `en`  in  1  display enable; 0 blanks outputs and the scan keeps running.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `an`  out  2  digit anodes, active-low; an[0] is units and an[1] is tens.

## Operation
- Prescaler `cnt` counts 0..REFRESH_DIV-1 and wraps. `tick` is asserted in the cycle where `cnt == REFRESH_DIV-1`.
- Digit select `sel` has two states, UNITS (0) and TENS (1). It toggles on each `tick`.
- Snapshot: on the `tick` where `sel` goes TENS→UNITS, `snap_t` and `snap_u` capture `tens` and `units`. This edge is the frame boundary. Inputs sampled at any other time are ignored.
- Decode, with hex values for active-low {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10
  - any code 10..15 gives a dash, 3F.
- Output register, updated every cycle from the current `sel`, snapshot and `en`:
  - `en=0`: an=11, seg=7F.
  - sel=UNITS: an=10, seg=decode(snap_u).
  - sel=TENS with `LZB=1` and snap_t==0: an=11, seg=7F. This is leading-zero blanking.
  - sel=TENS otherwise: an=01, seg=decode(snap_t).
- Invalid tens (10..15) is never blanked. It always shows a dash.
- Reset values: cnt=0, sel=UNITS, snap_t=snap_u=0, an=11, seg=7F.

## Timing
- Output register latency: 1 cycle from `sel`/`en`/snapshot change to `an`/`seg`.
- Each digit is lit for exactly REFRESH_DIV cycles. The frame period is 2·REFRESH_DIV cycles.
- First frame after reset release:
  - Cycles 1..REFRESH_DIV show units=0 (an=10, seg=40).
  - The tens slot then blanks when LZB=1.
  - The first capture happens at cycle 2·REFRESH_DIV.
- Input-change-to-display latency is at most 2·REFRESH_DIV+1 cycles.
- The counter increments once per clock and may change every cycle. The snapshot takes whatever pair is present on the capture edge. Both digits are captured in the same edge, so the pair is never torn.
- `en` toggles take effect on the next cycle. Deasserting `en` does not reset `cnt`, `sel` or the snapshot.
- `rst` mid-frame forces the reset values immediately, asynchronously. Scanning restarts at UNITS with cnt=0.

## Structure
- Shared package `bcd_disp_pkg`:
  - Segment constants `SEG_0`..`SEG_9`, `SEG_DASH=7'h3F`, `SEG_OFF=7'h7F`.
  - Anode constants `AN_UNITS=2'b10`, `AN_TENS=2'b01`, `AN_OFF=2'b11`.
  - Enum for `sel` (UNITS/TENS).
- Sub-module `bcd_to_7seg`: purely combinational 4-bit→7-bit decoder, instantiated once on the muxed snapshot digit.
- Prescaler width is $clog2(REFRESH_DIV).

## Test plan
All scenarios use REFRESH_DIV=4 and LZB=1 unless noted.
- Reset then tens=4, units=7 held:
  - Cycles 1–4: an=10, seg=40.
  - Cycles 5–8: an=11.
  - From cycle 9: units shows seg=78 with an=10 for 4 cycles, then tens shows seg=19 with an=01. This repeats with an 8-cycle period.
- tens=0, units=5:
  - LZB=1: tens slot has an=11, seg=7F.
  - LZB=0: tens slot has an=01, seg=40.
- Inputs change every cycle (counter driven each clock) → displayed pair equals exactly the input pair present on the capture edge, checked against a model.
- units=12, tens=15 → both slots show seg=3F. The tens slot is not blanked.
- en=0 for 10 cycles mid-frame → an=11, seg=7F starting 1 cycle later. On re-enable, the phase continues as if `en` had never dropped.
- rst pulsed mid tens-slot → an=11, seg=7F asynchronously. After release, cnt restarts and sel=UNITS, displaying units=0 (seg=40).
